alu_seq_ctrl: RTL and testbench

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_seq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Sequencer for an external N-bit ALU: decodes 8-bit ops, chains two byte passes for ADD16/SUB16.
// Latency: 8-bit ops done 1 cycle after accept; 16-bit ops done 2 cycles after accept.
// Backpressure: op_ready drops for the single high-byte cycle of a 16-bit op; otherwise 1 op/cycle.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   op_valid/op/op_ready    request handshake, 4-bit op code
//   s, cin, byte_sel        ALU select, carry/shift-in, operand byte select (1 = high byte)
//   C, V, Z, S              combinational ALU flags for the current s/cin/operands
//   flag_ld, flag_din       direct flag register load {C,V,Z,S}, wins over any op update
//   flags_q                 registered flags {C,V,Z,S}
//   cond, cond_true         condition code test against flags_q
//   done, err, busy         completion pulse, illegal-op pulse, 16-bit op in progress
module alu_seq_ctrl #(
    parameter int N = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       op_valid,
    input  logic [3:0] op,
    output logic       op_ready,
    output logic [2:0] s,
    output logic       cin,
    output logic       byte_sel,
    input  logic       C,
    input  logic       V,
    input  logic       Z,
    input  logic       S,
    input  logic       flag_ld,
    input  logic [3:0] flag_din,
    output logic [3:0] flags_q,
    input  logic [2:0] cond,
    output logic       cond_true,
    output logic       done,
    output logic       busy,
    output logic       err
);

    if (N < 1) begin : g_bad_width
        $error("alu_seq_ctrl: N must be at least 1");
    end

    typedef enum logic {IDLE, HI} state_t;

    localparam logic [3:0] OP_LAST8 = 4'd10;
    localparam logic [3:0] OP_ADD16 = 4'd11;
    localparam logic [3:0] OP_SUB16 = 4'd12;

    state_t     state, state_nxt;
    logic [3:0] op_q;
    logic       c_tmp, z_tmp;

    logic       flags_upd;
    logic [3:0] flags_new;
    logic       done_nxt, err_nxt;
    logic       ld16;

    always_comb begin
        state_nxt = state;
        op_ready  = 1'b0;
        busy      = 1'b0;
        byte_sel  = 1'b0;
        s         = 3'b000;
        cin       = 1'b0;
        flags_upd = 1'b0;
        flags_new = flags_q;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        ld16      = 1'b0;

        case (state)
            IDLE: begin
                op_ready = 1'b1;
                // s/cin follow op even without op_valid so the ALU flags are
                // already settled at the accepting edge.
                case (op)
                    4'd0:    begin s = 3'b000; cin = 1'b0;       end
                    4'd1:    begin s = 3'b000; cin = flags_q[3]; end
                    4'd2:    begin s = 3'b001; cin = 1'b1;       end
                    4'd3:    begin s = 3'b001; cin = flags_q[3]; end
                    4'd4:    begin s = 3'b010; cin = 1'b0;       end
                    4'd5:    begin s = 3'b011; cin = 1'b0;       end
                    4'd6:    begin s = 3'b011; cin = 1'b1;       end
                    4'd7:    begin s = 3'b100; cin = 1'b0;       end
                    4'd8:    begin s = 3'b101; cin = 1'b0;       end
                    4'd9:    begin s = 3'b110; cin = 1'b0;       end
                    4'd10:   begin s = 3'b111; cin = 1'b0;       end
                    4'd11:   begin s = 3'b000; cin = 1'b0;       end
                    4'd12:   begin s = 3'b001; cin = 1'b1;       end
                    default: begin s = 3'b000; cin = 1'b0;       end
                endcase

                if (op_valid) begin
                    if (op <= OP_LAST8) begin
                        flags_upd = 1'b1;
                        flags_new = {C, V, Z, S};
                        done_nxt  = 1'b1;
                    end else if (op == OP_ADD16 || op == OP_SUB16) begin
                        ld16      = 1'b1;
                        state_nxt = HI;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end

            HI: begin
                busy      = 1'b1;
                byte_sel  = 1'b1;
                s         = (op_q == OP_SUB16) ? 3'b001 : 3'b000;
                cin       = c_tmp;
                // 16-bit zero needs both bytes zero; C/V/S come from the high byte alone.
                flags_upd = 1'b1;
                flags_new = {C, V, Z & z_tmp, S};
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            flags_q <= 4'b0000;
            op_q    <= 4'd0;
            c_tmp   <= 1'b0;
            z_tmp   <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
            err   <= err_nxt;
            if (flag_ld) begin
                flags_q <= flag_din;
            end else if (flags_upd) begin
                flags_q <= flags_new;
            end
            if (ld16) begin
                op_q  <= op;
                c_tmp <= C;
                z_tmp <= Z;
            end
        end
    end

    always_comb begin
        case (cond)
            3'b000:  cond_true = 1'b1;
            3'b001:  cond_true = flags_q[1];
            3'b010:  cond_true = !flags_q[1];
            3'b011:  cond_true = flags_q[3];
            3'b100:  cond_true = !flags_q[3];
            3'b101:  cond_true = flags_q[0];
            3'b110:  cond_true = flags_q[2];
            default: cond_true = flags_q[0] ^ flags_q[2];
        endcase
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: an 8-bit ALU is emulated around the DUT, and a transaction-level
// model computes flags from whole-word arithmetic (16-bit ops as one 16-bit operation).
// Directed vectors pin the model with literal values; a randomized phase follows.
module tb_alu_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       op_valid = 1'b0;
    logic [3:0] op = 4'd0;
    logic       op_ready;
    logic [2:0] s;
    logic       cin;
    logic       byte_sel;
    logic       alu_c, alu_v, alu_z, alu_s;
    logic       flag_ld = 1'b0;
    logic [3:0] flag_din = 4'd0;
    logic [3:0] flags_q;
    logic [2:0] cond = 3'd0;
    logic       cond_true;
    logic       done, busy, err;

    logic [15:0] a16 = 16'd0;
    logic [15:0] b16 = 16'd0;

    int total = 0;
    int bad   = 0;

    // transaction-level model state
    logic [3:0] m_flags = 4'd0;
    logic       m_busy  = 1'b0;
    logic       m_done  = 1'b0;
    logic       m_err   = 1'b0;
    int         m_op16  = 0;
    int         m_a     = 0;
    int         m_b     = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.N(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_valid  (op_valid),
        .op        (op),
        .op_ready  (op_ready),
        .s         (s),
        .cin       (cin),
        .byte_sel  (byte_sel),
        .C         (alu_c),
        .V         (alu_v),
        .Z         (alu_z),
        .S         (alu_s),
        .flag_ld   (flag_ld),
        .flag_din  (flag_din),
        .flags_q   (flags_q),
        .cond      (cond),
        .cond_true (cond_true),
        .done      (done),
        .busy      (busy),
        .err       (err)
    );

    // Emulated 8-bit ALU fed by byte-selected operands.
    logic [7:0] ea, eb, er;
    logic [8:0] et;
    always_comb begin
        ea = byte_sel ? a16[15:8] : a16[7:0];
        eb = byte_sel ? b16[15:8] : b16[7:0];
        et = 9'd0;
        er = 8'd0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (s)
            3'b000: begin
                et = {1'b0, ea} + {1'b0, eb} + {8'd0, cin};
                er = et[7:0];
                alu_c = et[8];
                alu_v = (ea[7] == eb[7]) && (er[7] != ea[7]);
            end
            3'b001: begin
                et = {1'b0, ea} + {1'b0, ~eb} + {8'd0, cin};
                er = et[7:0];
                alu_c = et[8];
                alu_v = (ea[7] != eb[7]) && (er[7] != ea[7]);
            end
            3'b010: begin er = {ea[6:0], cin}; alu_c = ea[7]; end
            3'b011: begin er = {cin ? ea[7] : 1'b0, ea[7:1]}; alu_c = ea[0]; end
            3'b100: er = ea & eb;
            3'b101: er = ea | eb;
            3'b110: er = ea ^ eb;
            default: er = ~ea;
        endcase
        alu_z = (er == 8'd0);
        alu_s = er[7];
    end

    function automatic int sx8(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    function automatic int sx16(input int x);
        return (x >= 32768) ? x - 65536 : x;
    endfunction

    // Flags {C,V,Z,S} of an 8-bit op from plain integer arithmetic.
    function automatic logic [3:0] ref8(input int opc, input int a, input int b, input int cf);
        int r, c, sv, ci;
        bit v;
        c = 0; v = 0; r = 0; sv = 0;
        ci = (opc == 1 || opc == 3) ? cf : ((opc == 2) ? 1 : 0);
        case (opc)
            0, 1: begin
                r = a + b + ci; c = r >> 8;
                sv = sx8(a) + sx8(b) + ci; v = (sv > 127) || (sv < -128);
            end
            2, 3: begin
                r = a + (255 - b) + ci; c = r >> 8;
                sv = sx8(a) - sx8(b) - (1 - ci); v = (sv > 127) || (sv < -128);
            end
            4: begin r = a << 1; c = a >> 7; end
            5: begin r = a >> 1; c = a & 1; end
            6: begin r = (a >> 1) | (a & 128); c = a & 1; end
            7: r = a & b;
            8: r = a | b;
            9: r = a ^ b;
            default: r = 255 - a;
        endcase
        r = r & 255;
        return {c[0], v, (r == 0), r[7]};
    endfunction

    // Flags of a full 16-bit add/subtract.
    function automatic logic [3:0] ref16(input bit sub, input int a, input int b);
        int r, sv;
        if (sub) begin
            r = a + (65535 - b) + 1;
            sv = sx16(a) - sx16(b);
        end else begin
            r = a + b;
            sv = sx16(a) + sx16(b);
        end
        return {r[16], (sv > 32767) || (sv < -32768), (r[15:0] == 16'd0), r[15]};
    endfunction

    // Expected {s, cin} while idle.
    function automatic logic [3:0] exp_sc(input int o, input logic cf);
        case (o)
            0:  return 4'b0000;
            1:  return {3'b000, cf};
            2:  return 4'b0011;
            3:  return {3'b001, cf};
            4:  return 4'b0100;
            5:  return 4'b0110;
            6:  return 4'b0111;
            7:  return 4'b1000;
            8:  return 4'b1010;
            9:  return 4'b1100;
            10: return 4'b1110;
            11: return 4'b0000;
            12: return 4'b0011;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic ref_cond(input logic [2:0] c, input logic [3:0] f);
        case (c)
            3'd0: return 1'b1;
            3'd1: return f[1];
            3'd2: return !f[1];
            3'd3: return f[3];
            3'd4: return !f[3];
            3'd5: return f[0];
            3'd6: return f[2];
            default: return f[0] ^ f[2];
        endcase
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [3:0] sc;
        int lc;
        if (m_busy) begin
            if (m_op16 == 12) lc = ((m_a & 255) + (255 - (m_b & 255)) + 1) >> 8;
            else              lc = ((m_a & 255) + (m_b & 255)) >> 8;
            sc = {(m_op16 == 12) ? 3'b001 : 3'b000, lc[0]};
        end else begin
            sc = exp_sc(int'(op), m_flags[3]);
        end
        chk("s",         16'(s),         16'(sc[3:1]));
        chk("cin",       16'(cin),       16'(sc[0]));
        chk("op_ready",  16'(op_ready),  16'(!m_busy));
        chk("busy",      16'(busy),      16'(m_busy));
        chk("byte_sel",  16'(byte_sel),  16'(m_busy));
        chk("flags_q",   16'(flags_q),   16'(m_flags));
        chk("done",      16'(done),      16'(m_done));
        chk("err",       16'(err),       16'(m_err));
        chk("cond_true", 16'(cond_true), 16'(ref_cond(cond, m_flags)));
    endtask

    task automatic apply(input logic v, input logic [3:0] o, input logic [15:0] a,
                         input logic [15:0] b, input logic fl, input logic [3:0] fd,
                         input logic [2:0] cd);
        op_valid = v;
        op       = o;
        // operands of an in-flight 16-bit op stay put for its high pass
        if (!m_busy) begin
            a16 = a;
            b16 = b;
        end
        flag_ld  = fl;
        flag_din = fd;
        cond     = cd;
    endtask

    // Check mid-cycle, advance the model across the edge, return at edge + 1.
    task automatic step();
        logic [3:0] nf;
        logic nb, nd, ne;
        @(negedge clk);
        check_outputs();
        nf = m_flags; nb = m_busy; nd = 1'b0; ne = 1'b0;
        if (m_busy) begin
            nf = ref16(m_op16 == 12, m_a, m_b);
            nb = 1'b0;
            nd = 1'b1;
        end else if (op_valid) begin
            if (op <= 4'd10) begin
                nf = ref8(int'(op), int'(a16[7:0]), int'(b16[7:0]), int'(m_flags[3]));
                nd = 1'b1;
            end else if (op == 4'd11 || op == 4'd12) begin
                nb = 1'b1;
                m_op16 = int'(op);
                m_a = int'(a16);
                m_b = int'(b16);
            end else begin
                ne = 1'b1;
            end
        end
        if (flag_ld) nf = flag_din;
        @(posedge clk);
        #1;
        m_flags = nf; m_busy = nb; m_done = nd; m_err = ne;
    endtask

    // Asynchronous reset asserted between edges, held across one edge.
    task automatic hard_reset();
        rst_n = 1'b0;
        #1;
        m_flags = 4'd0; m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
        check_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 7))
            0: return 16'hFFFF;
            1: return 16'h0000;
            2: return 16'h8000;
            3: return 16'h7F7F;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        #2;
        chk("rst flags_q", 16'(flags_q), 16'h0);
        chk("rst done",    16'(done),    16'h0);
        chk("rst err",     16'(err),     16'h0);
        chk("rst busy",    16'(busy),    16'h0);
        chk("rst ready",   16'(op_ready),16'h1);
        check_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ADD 0x7F + 0x01
        apply(1'b1, 4'd0, 16'h007F, 16'h0001, 1'b0, 4'd0, 3'b111);
        #1;
        chk("add s",   16'(s),   16'h0);
        chk("add cin", 16'(cin), 16'h0);
        step();
        chk("add flags", 16'(flags_q),   16'b0101);
        chk("add done",  16'(done),      16'h1);
        chk("add cond",  16'(cond_true), 16'h0);

        // ADD16 0xFFFF + 0x0001
        apply(1'b1, 4'd11, 16'hFFFF, 16'h0001, 1'b0, 4'd0, 3'b000);
        #1;
        chk("add16 lo byte_sel", 16'(byte_sel), 16'h0);
        step();
        chk("add16 hi byte_sel", 16'(byte_sel), 16'h1);
        chk("add16 hi cin",      16'(cin),      16'h1);
        chk("add16 hi busy",     16'(busy),     16'h1);
        chk("add16 hi ready",    16'(op_ready), 16'h0);
        apply(1'b1, 4'd2, 16'h0000, 16'h0000, 1'b0, 4'd0, 3'b000);
        step();
        chk("add16 flags", 16'(flags_q), 16'b1010);
        chk("add16 done",  16'(done),    16'h1);

        // SUB16 0x0100 - 0x0001
        apply(1'b1, 4'd12, 16'h0100, 16'h0001, 1'b0, 4'd0, 3'b000);
        #1;
        chk("sub16 lo cin", 16'(cin), 16'h1);
        step();
        chk("sub16 hi cin", 16'(cin), 16'h0);
        apply(1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 4'd0, 3'b000);
        step();
        chk("sub16 flags", 16'(flags_q), 16'b1000);

        // flag_ld beats the ADD update; ADC then uses the loaded carry
        apply(1'b1, 4'd0, 16'h0001, 16'h0001, 1'b1, 4'b1000, 3'b000);
        step();
        chk("ld flags", 16'(flags_q), 16'b1000);
        apply(1'b1, 4'd1, 16'h00FF, 16'h0000, 1'b0, 4'd0, 3'b000);
        #1;
        chk("adc cin", 16'(cin), 16'h1);
        step();
        chk("adc flags", 16'(flags_q), 16'b1010);

        // illegal op
        apply(1'b1, 4'd14, 16'h1234, 16'h5678, 1'b0, 4'd0, 3'b000);
        step();
        chk("ill err",   16'(err),     16'h1);
        chk("ill done",  16'(done),    16'h0);
        chk("ill flags", 16'(flags_q), 16'b1010);

        // reset during the high pass aborts the 16-bit op
        apply(1'b1, 4'd11, 16'h1234, 16'h4321, 1'b0, 4'd0, 3'b000);
        step();
        chk("abort busy", 16'(busy), 16'h1);
        hard_reset();
        chk("abort flags", 16'(flags_q), 16'h0);
        chk("abort idle",  16'(busy),    16'h0);
        apply(1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 4'd0, 3'b000);
        step();
        chk("abort done", 16'(done), 16'h0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                hard_reset();
            end else begin
                apply($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), pick16(), pick16(),
                      $urandom_range(0, 9) == 0, 4'($urandom), 3'($urandom));
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
